// File: rtl/m31_pkg.sv
// m31_pkg: shared M31 field type, modulus and pipeline latencies
package m31_pkg;
  typedef logic [30:0] m31_t;
  localparam m31_t P_M31 = 31'h7fffffff;
  localparam int M31_MUL_LAT = 4;
  localparam int SBOX_LAT = 3 * M31_MUL_LAT;
endpackage

// File: rtl/m31_mul.sv
// m31_mul: 4-stage pipelined multiplier mod 2^31-1 with canonical output
module m31_mul
  import m31_pkg::*;
(
  input  logic clk,
  input  m31_t a,
  input  m31_t b,
  output m31_t p
);
  m31_t a_q, b_q, fold;
  logic [61:0] prod_q;
  logic [31:0] sum_q;
  // 2^31 == 1 mod P, so the high half folds onto the low half; the result never exceeds P
  assign fold = sum_q[30:0] + m31_t'(sum_q[31]);
  always_ff @(posedge clk) begin
    a_q <= a;
    b_q <= b;
    prod_q <= 62'(a_q) * 62'(b_q);
    sum_q <= {1'b0, prod_q[30:0]} + {1'b0, prod_q[61:31]};
    p <= (fold == P_M31) ? '0 : fold;
  end
endmodule

// File: rtl/m31_sync_fifo.sv
// m31_sync_fifo: show-ahead synchronous FIFO with occupancy count
module m31_sync_fifo
  import m31_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_en,
  input  logic rd_en,
  input  m31_t wr_data,
  output m31_t rd_data,
  output logic empty,
  output logic [AW:0] count
);
  m31_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign empty = count == '0;
  assign rd_data = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_en);
      rd_ptr <= rd_ptr + AW'(rd_en);
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk)
    if (rst_n) assert (!(wr_en && !rd_en && count == (AW+1)'(DEPTH)) && !(rd_en && empty));
endmodule

// File: rtl/m31_sbox_pow5.sv
// m31_sbox_pow5: streaming x^5 mod 2^31-1 S-box; occupancy credits keep the
// non-stallable multiplier chain from ever overflowing the output FIFO
module m31_sbox_pow5
  import m31_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  m31_t in_data,
  output logic out_valid,
  input  logic out_ready,
  output m31_t out_data
);
  localparam int DL = 2 * M31_MUL_LAT;
  logic accept, pop, fifo_empty;
  logic [CW-1:0] occ, fifo_count;
  logic [SBOX_LAT-1:0] vld;
  m31_t x_dl [DL];
  m31_t x2, x4, x5;
  assign accept = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign in_ready = occ < CW'(FIFO_DEPTH);
  assign out_valid = !fifo_empty;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      occ <= '0;
      vld <= '0;
    end else begin
      occ <= occ + CW'(accept) - CW'(pop);
      vld <= {vld[SBOX_LAT-2:0], accept};
    end
  // x rides alongside the x^2 and x^4 stages to meet x^4 at the last multiplier
  always_ff @(posedge clk) begin
    x_dl[0] <= in_data;
    for (int i = 1; i < DL; i++) x_dl[i] <= x_dl[i-1];
  end
  m31_mul u_mul0 (.clk, .a(in_data), .b(in_data), .p(x2));
  m31_mul u_mul1 (.clk, .a(x2), .b(x2), .p(x4));
  m31_mul u_mul2 (.clk, .a(x4), .b(x_dl[DL-1]), .p(x5));
  m31_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk, .rst_n, .wr_en(vld[SBOX_LAT-1]), .rd_en(pop), .wr_data(x5),
    .rd_data(out_data), .empty(fifo_empty), .count(fifo_count)
  );
  always_ff @(posedge clk)
    if (rst_n && accept) assert (in_data < P_M31);
  always_ff @(posedge clk)
    if (rst_n) assert (fifo_count <= occ);
endmodule
